// File: rtl/cpu_controller_pkg.sv
// Shared constants for the CR16-subset control path: state codes, opcode/opext fields,
// PC-source selects and the one-hot instruction-class bit positions.
package cpu_defs;
    localparam int WIDTH = 16;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC_R  = 4'd2;
    localparam logic [3:0] S_EXEC_I  = 4'd3;
    localparam logic [3:0] S_MEM_RD  = 4'd4;
    localparam logic [3:0] S_LOAD_WB = 4'd5;
    localparam logic [3:0] S_STORE   = 4'd6;
    localparam logic [3:0] S_BRANCH  = 4'd7;
    localparam logic [3:0] S_HALT    = 4'd15;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_DISP = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

    localparam int CLS_RTYPE   = 0;
    localparam int CLS_ITYPE   = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STOR    = 3;
    localparam int CLS_JCOND   = 4;
    localparam int CLS_BCOND   = 5;
    localparam int CLS_ILLEGAL = 6;
    localparam int CLS_W       = 7;

    // ADD, SUB and CMP share the same 4-bit code whether it sits in opcode or opext.
    function automatic logic sets_flags(input logic [3:0] code);
        return (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);
    endfunction
endpackage

// File: rtl/cpu_controller_instr_class_decode.sv
// Combinational instruction classifier: one-hot class plus CMP / logical-immediate /
// flag-setting qualifiers derived from the opcode and opext fields.
module instr_class_decode
    import cpu_defs::*;
(
    input  logic [WIDTH-1:0] i_instr,
    output logic [CLS_W-1:0] o_cls,
    output logic             o_is_cmp,
    output logic             o_is_logic,
    output logic             o_is_flag
);
    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic       w_unused_fields;

    assign w_op            = i_instr[15:12];
    assign w_ext           = i_instr[7:4];
    assign w_unused_fields = ^{i_instr[11:8], i_instr[3:0]};

    always_comb begin
        o_cls = '0;
        case (w_op)
            OP_RTYPE: o_cls[CLS_RTYPE] = 1'b1;
            OP_MEM: begin
                case (w_ext)
                    EXT_LOAD:  o_cls[CLS_LOAD]    = 1'b1;
                    EXT_STOR:  o_cls[CLS_STOR]    = 1'b1;
                    EXT_JCOND: o_cls[CLS_JCOND]   = 1'b1;
                    default:   o_cls[CLS_ILLEGAL] = 1'b1;
                endcase
            end
            OP_BCOND: o_cls[CLS_BCOND] = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI:
                o_cls[CLS_ITYPE] = 1'b1;
            default: o_cls[CLS_ILLEGAL] = 1'b1;
        endcase
    end

    assign o_is_cmp   = (o_cls[CLS_RTYPE] && (w_ext == EXT_CMP)) || (w_op == OP_CMPI);
    assign o_is_logic = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
    assign o_is_flag  = (o_cls[CLS_RTYPE] && sets_flags(w_ext)) ||
                        (o_cls[CLS_ITYPE] && sets_flags(w_op));
endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for the CR16 subset.
// Outputs are decoded from registered state plus latched instr; all forced low while reset is low.
module cpu_controller
    import cpu_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             cond_true,
    output logic             irwrite,
    output logic             pcen,
    output logic [1:0]       pcsrc,
    output logic             iord,
    output logic             we_a,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             alusrcb,
    output logic             immzext,
    output logic             flagwrite,
    output logic             halted,
    output logic [3:0]       state_o
);
    logic [3:0]       r_state;
    logic             r_run;
    logic [3:0]       w_next;
    logic [CLS_W-1:0] w_cls;
    logic             w_is_cmp;
    logic             w_is_logic;
    logic             w_is_flag;

    instr_class_decode u_decode (
        .i_instr    (instr),
        .o_cls      (w_cls),
        .o_is_cmp   (w_is_cmp),
        .o_is_logic (w_is_logic),
        .o_is_flag  (w_is_flag)
    );

    // r_run holds everything idle until the first edge after release, so FETCH begins there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run)
                r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (w_cls[CLS_RTYPE])                         w_next = S_EXEC_R;
                else if (w_cls[CLS_ITYPE])                    w_next = S_EXEC_I;
                else if (w_cls[CLS_LOAD])                     w_next = S_MEM_RD;
                else if (w_cls[CLS_STOR])                     w_next = S_STORE;
                else if (w_cls[CLS_JCOND] || w_cls[CLS_BCOND]) w_next = S_BRANCH;
                else                                          w_next = S_HALT;
            end
            S_MEM_RD: w_next = S_LOAD_WB;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        irwrite   = 1'b0;
        pcen      = 1'b0;
        pcsrc     = PC_INC;
        iord      = 1'b0;
        we_a      = 1'b0;
        regwrite  = 1'b0;
        memtoreg  = 1'b0;
        alusrcb   = 1'b0;
        immzext   = 1'b0;
        flagwrite = 1'b0;
        halted    = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: irwrite = 1'b1;
                S_EXEC_R, S_EXEC_I: begin
                    alusrcb   = (r_state == S_EXEC_I);
                    immzext   = (r_state == S_EXEC_I) && w_is_logic;
                    regwrite  = !w_is_cmp;
                    flagwrite = w_is_flag;
                    pcen      = 1'b1;
                end
                S_MEM_RD: iord = 1'b1;
                S_LOAD_WB: begin
                    iord     = 1'b1;
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    pcen     = 1'b1;
                end
                S_STORE: begin
                    iord = 1'b1;
                    we_a = 1'b1;
                    pcen = 1'b1;
                end
                S_BRANCH: begin
                    pcen = 1'b1;
                    if (cond_true)
                        pcsrc = w_cls[CLS_BCOND] ? PC_DISP : PC_REG;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = r_state;
endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: per-cycle expected output words are queued with each
// instruction and popped/compared one cycle at a time.
module tb_cpu_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        cond_true;
    logic        irwrite, pcen, iord, we_a, regwrite, memtoreg, alusrcb, immzext, flagwrite, halted;
    logic [1:0]  pcsrc;
    logic [3:0]  state_o;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    // Observation word: {state, irwrite, pcen, pcsrc[1:0], iord, we_a, regwrite, memtoreg,
    //                    alusrcb, immzext, flagwrite, halted}
    localparam logic [11:0] IRW     = 12'h800;
    localparam logic [11:0] PCEN    = 12'h400;
    localparam logic [11:0] PS_REG  = 12'h200;
    localparam logic [11:0] PS_DISP = 12'h100;
    localparam logic [11:0] IORD    = 12'h080;
    localparam logic [11:0] WEA     = 12'h040;
    localparam logic [11:0] RW      = 12'h020;
    localparam logic [11:0] MTR     = 12'h010;
    localparam logic [11:0] ASB     = 12'h008;
    localparam logic [11:0] IZX     = 12'h004;
    localparam logic [11:0] FW      = 12'h002;
    localparam logic [11:0] HLT     = 12'h001;

    logic [15:0] obs;
    assign obs = {state_o, irwrite, pcen, pcsrc, iord, we_a, regwrite, memtoreg,
                  alusrcb, immzext, flagwrite, halted};

    cpu_controller dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .cond_true (cond_true),
        .irwrite   (irwrite),
        .pcen      (pcen),
        .pcsrc     (pcsrc),
        .iord      (iord),
        .we_a      (we_a),
        .regwrite  (regwrite),
        .memtoreg  (memtoreg),
        .alusrcb   (alusrcb),
        .immzext   (immzext),
        .flagwrite (flagwrite),
        .halted    (halted),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [3:0] st, input logic [11:0] f);
        exp_q.push_back({st, f});
    endtask

    task automatic push_fetch_decode();
        push(4'd0, IRW);
        push(4'd1, 12'h000);
    endtask

    task automatic drain(input string name);
        logic [15:0] e;
        int step = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s step%0d: got %h want %h", name, step, obs, e);
            end
            step++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr = 16'h0000;
        cond_true = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (obs !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold: got %h want 0000", obs);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (obs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_release_pre_edge: got %h want 0000", obs);
        end
    endtask

    task automatic test_rtype_add();
        instr = 16'h0351;
        cond_true = 1'b1;
        push_fetch_decode();
        push(4'd2, PCEN | RW | FW);
        drain("add_r3_r1");
        cond_true = 1'b0;
    endtask

    task automatic test_load();
        instr = 16'h4204;
        push_fetch_decode();
        push(4'd4, IORD);
        push(4'd5, IORD | MTR | RW | PCEN);
        drain("load_r2");
    endtask

    task automatic test_branch();
        instr = 16'hC0FE;
        cond_true = 1'b1;
        push_fetch_decode();
        push(4'd7, PCEN | PS_DISP);
        drain("bcond_taken");
        cond_true = 1'b0;
        push_fetch_decode();
        push(4'd7, PCEN);
        drain("bcond_not_taken");
        instr = 16'h40C3;
        cond_true = 1'b1;
        push_fetch_decode();
        push(4'd7, PCEN | PS_REG);
        drain("jcond_taken");
        cond_true = 1'b0;
    endtask

    task automatic test_itype();
        instr = 16'hB512;
        push_fetch_decode();
        push(4'd3, ASB | FW | PCEN);
        drain("cmpi");
        instr = 16'h1234;
        push_fetch_decode();
        push(4'd3, ASB | IZX | RW | PCEN);
        drain("andi");
    endtask

    task automatic test_back_to_back();
        instr = 16'h5103;
        push_fetch_decode();
        push(4'd3, ASB | RW | FW | PCEN);
        drain("addi");
        instr = 16'h03B1;
        push_fetch_decode();
        push(4'd2, FW | PCEN);
        drain("cmp_r");
        instr = 16'h0291;
        push_fetch_decode();
        push(4'd2, RW | FW | PCEN);
        drain("sub_r");
    endtask

    task automatic test_illegal_halt();
        instr = 16'hF000;
        cond_true = 1'b1;
        push_fetch_decode();
        repeat (10) push(4'd15, HLT);
        drain("illegal_halt");
        cond_true = 1'b0;
    endtask

    task automatic test_reset_during_store();
        reset = 1'b0;
        #1;
        total++;
        if (obs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_from_halt: got %h want 0000", obs);
        end
        @(negedge clk);
        reset = 1'b1;
        instr = 16'h4142;
        push_fetch_decode();
        drain("store_pre");
        @(posedge clk);
        #1;
        total++;
        if (obs !== {4'd6, PCEN | IORD | WEA}) begin
            bad++;
            $display("FAIL store_state: got %h want %h", obs, {4'd6, PCEN | IORD | WEA});
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (we_a !== 1'b0 || obs !== 16'h0000) begin
            bad++;
            $display("FAIL store_abort: got %h want 0000", obs);
        end
        @(negedge clk);
        reset = 1'b1;
        instr = 16'h0351;
        push_fetch_decode();
        push(4'd2, PCEN | RW | FW);
        drain("add_after_abort");
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_load();
        test_branch();
        test_itype();
        test_back_to_back();
        test_illegal_halt();
        test_reset_during_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control FSM for the 16-bit CR16-subset processor. It sequences the shared datapath (register file, ALU, instruction register, PC and memory port A of the dual-port BRAM) over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It generates every datapath enable and mux select from the latched instruction and the branch-condition flag. It sits between the instruction register and the datapath muxes; memory port B and the memory-mapped LED/switch logic are outside its scope.

## Interface
- WIDTH, 16, instruction/data width
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; low forces FETCH and all outputs to 0
- instr  in  WIDTH  latched instruction register contents: [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc/imm
- cond_true  in  1  datapath evaluation of instr[11:8] condition code against the PSR flags
- irwrite  out  1  load instruction register from memory port A read data
- pcen  out  1  update PC
- pcsrc  out  2  PC next: 00 PC+1, 01 PC+sign-extended 8-bit displacement, 10 Rsrc register value
- iord  out  1  port A address: 0 PC, 1 Rsrc register value
- we_a  out  1  port A write enable (data = Rdest value)
- regwrite  out  1  register file write of Rdest
- memtoreg  out  1  writeback source: 0 ALU result, 1 port A read data
- alusrcb  out  1  ALU B operand: 0 Rsrc register, 1 immediate
- immzext  out  1  immediate extension: 0 sign-extend 8-bit, 1 zero-extend (logical ops)
- flagwrite  out  1  latch ALU flags into PSR
- halted  out  1  high in HALT
- state_o  out  4  current state encoding, for debug/LEDs

## Operation
- Instruction classes, decoded from instr:
  - RTYPE: opcode 0000.
  - LOAD: opcode 0100, opext 0000.
  - STOR: opcode 0100, opext 0100.
  - JCOND: opcode 0100, opext 1100.
  - BCOND: opcode 1100.
  - ITYPE: opcodes 0001, 0010, 0011, 0101, 1001, 1011, 1101.
  - Anything else: ILLEGAL.
- CMP (RTYPE opext 1011, ITYPE opcode 1011) sets flagwrite but not regwrite. ADD/SUB forms set both flagwrite and regwrite.
- Immediate logical ops (opcodes 0001, 0010, 0011) assert immzext in EXEC_I.
- States and per-state outputs (outputs not named are 0):
  - FETCH: iord=0, irwrite=1. Next: DECODE.
  - DECODE: no outputs asserted. Next: EXEC_R, EXEC_I, MEM_RD, STORE, BRANCH, or HALT (ILLEGAL).
  - EXEC_R: alusrcb=0, regwrite=1 unless CMP, flagwrite per opcode, pcen=1, pcsrc=00. Next: FETCH.
  - EXEC_I: as EXEC_R with alusrcb=1. Next: FETCH.
  - MEM_RD: iord=1. Next: LOAD_WB.
  - LOAD_WB: iord=1, memtoreg=1, regwrite=1, pcen=1, pcsrc=00. Next: FETCH.
  - STORE: iord=1, we_a=1, pcen=1, pcsrc=00. Next: FETCH.
  - BRANCH: pcen=1. pcsrc=01 (BCOND) or 10 (JCOND) when cond_true, else pcsrc=00. Next: FETCH.
  - HALT: halted=1, no other outputs. Stays in HALT until reset.
- cond_true is sampled only in BRANCH. Its value in all other states is ignored.
- All outputs are decoded from the registered state and the latched instr (Moore plus instr). No output depends on cond_true outside BRANCH.

## Timing
- While reset is low, state=FETCH and every output is 0, including halted. The first FETCH cycle starts on the first rising edge after reset deasserts.
- The BRAM is clocked on the falling edge, so read data for an address driven in a cycle is valid before that cycle's rising edge. irwrite in FETCH therefore captures the correct word.
- Cycles per instruction:
  - RTYPE, ITYPE, STOR, BCOND, JCOND: 3.
  - LOAD: 4.
  - ILLEGAL: 2, then HALT.
- PC updates exactly once per instruction, on the final cycle. A not-taken branch still increments the PC.
- Reset asserted mid-instruction aborts it immediately; no partial writes complete after reset goes low.

## Structure
- Shared include/package cpu_defs holds:
  - state encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_RD=4, LOAD_WB=5, STORE=6, BRANCH=7, HALT=15;
  - opcode and opext constants;
  - pcsrc codes.
- One combinational sub-module, instr_class_decode, maps instr to a one-hot class plus is_cmp and is_logic. The FSM lives in cpu_controller.

## Test plan
- Reset low for 3 cycles with instr=16'h0000 -> state_o=0, all outputs 0. First edge after release: irwrite=1, iord=0.
- instr=16'h0351 (ADD R3,R1) -> FETCH, DECODE, EXEC_R. Exactly one cycle with regwrite=1, flagwrite=1, pcen=1, pcsrc=00.
- instr=16'h4204 (LOAD R2,[R4]) -> 4 cycles. MEM_RD has iord=1 with regwrite=0. LOAD_WB has memtoreg=1, regwrite=1, pcen=1.
- instr=16'hC0FE (BCOND disp -2) with cond_true=1 -> BRANCH has pcsrc=01, pcen=1. Repeat with cond_true=0 -> pcsrc=00, pcen=1.
- instr=16'hB512 (CMPI) -> EXEC_I has flagwrite=1, regwrite=0, alusrcb=1, immzext=0.
- instr=16'hF000 (illegal) -> HALT with halted=1, held 10 cycles. Assert reset during STORE -> we_a drops to 0 with no clock edge required.
